// File: rtl/ps2_lane_decoder_if.sv
// ps2_lane_decoder_if: scancode input and lane/event output bundle of ps2_lane_decoder
// slave  (decoder): valid, make_break, out_code, evt_ready in; key_held, key_press,
//                   key_release, evt_valid, evt_data, evt_overflow out
// master (driver/consumer): mirror of slave
interface ps2_lane_decoder_if;
  logic       valid;
  logic       make_break;
  logic [7:0] out_code;
  logic [5:0] key_held;
  logic [5:0] key_press;
  logic [5:0] key_release;
  logic       evt_valid;
  logic [3:0] evt_data;
  logic       evt_ready;
  logic       evt_overflow;
  modport slave (
    input  valid, make_break, out_code, evt_ready,
    output key_held, key_press, key_release, evt_valid, evt_data, evt_overflow
  );
  modport master (
    output valid, make_break, out_code, evt_ready,
    input  key_held, key_press, key_release, evt_valid, evt_data, evt_overflow
  );
endinterface

// File: rtl/ps2_lane_decoder.sv
// ps2_lane_decoder: synchronous PS/2 scancode to six-lane held/press/release decoder with FWFT event FIFO
// Ports: clk (CLOCK_50), resetn (sync active-low), bus (ps2_lane_decoder_if.slave).
// Optional macro KEY_TIMEOUT_EN: force-release all lanes after TIMEOUT_CYCLES idle cycles.
module ps2_lane_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input logic               clk,
  input logic               resetn,
  ps2_lane_decoder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_q, hit, dec, cur, tmo, push, wr, pop, full, ovf;
  logic [2:0]             lane;
  logic [5:0]             oh, held_q, press_q, rel_q, held_nx, press_nx, rel_nx;
  logic [3:0]             push_data;
  logic [3:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wptr, rptr;
  logic [CW-1:0]          cnt;
  always_comb begin
    hit  = 1'b1;
    lane = '0;
    case (bus.out_code)
      8'h15:   lane = 3'd0;
      8'h1D:   lane = 3'd1;
      8'h24:   lane = 3'd2;
      8'h1C:   lane = 3'd3;
      8'h1B:   lane = 3'd4;
      8'h23:   lane = 3'd5;
      default: hit  = 1'b0;
    endcase
  end
  assign dec = sync[SYNC_STAGES-1] & ~sync_q & hit;
  assign oh  = 6'(1) << lane;
  assign cur = |(held_q & oh);
`ifdef KEY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle;
  // any decoded lane edge, even a typematic repeat, counts as activity
  assign tmo = (held_q != '0) && !dec && (idle == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk)
    idle <= (!resetn || held_q == '0 || dec || tmo) ? '0 : idle + TW'(1);
`else
  logic unused_tmo;
  assign tmo        = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif
  // a lane edge is meaningful only when it changes the held state, so it is a toggle
  always_comb begin
    held_nx   = held_q;
    press_nx  = '0;
    rel_nx    = '0;
    push      = 1'b0;
    push_data = {bus.make_break, lane};
    if (dec && (bus.make_break != cur)) begin
      held_nx  = held_q ^ oh;
      press_nx = bus.make_break ? oh : '0;
      rel_nx   = bus.make_break ? '0 : oh;
      push     = 1'b1;
    end
    if (tmo) begin
      held_nx   = '0;
      rel_nx    = held_q;
      push      = 1'b1;
      push_data = 4'b0111;
    end
  end
  assign full = cnt[AW];
  assign pop  = (cnt != '0) & bus.evt_ready;
  // a pop frees the slot in the same cycle, so push is accepted even when full
  assign wr   = push & (~full | pop);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync    <= '0;
      sync_q  <= 1'b0;
      held_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], bus.valid};
      sync_q  <= sync[SYNC_STAGES-1];
      held_q  <= held_nx;
      press_q <= press_nx;
      rel_q   <= rel_nx;
      wptr    <= wr ? wptr + AW'(1) : wptr;
      rptr    <= pop ? rptr + AW'(1) : rptr;
      cnt     <= cnt + CW'(wr) - CW'(pop);
      ovf     <= ovf | (push & full & ~pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn)
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    else if (wr)
      mem[wptr] <= push_data;
  end
  assign bus.key_held     = held_q;
  assign bus.key_press    = press_q;
  assign bus.key_release  = rel_q;
  assign bus.evt_valid    = cnt != '0;
  assign bus.evt_data     = mem[rptr];
  assign bus.evt_overflow = ovf;
endmodule
